layer_neuron_pipe: RTL and testbench

LAYER_NEURON_PIPE -- requirements
Module: layer_neuron_pipe

---
 rtl/layer_neuron_pipe.sv | 87 ++++++++
 tb/tb_layer_neuron_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/layer_neuron_pipe.sv
// Runtime-programmable lookup-table neuron behind a two-stage valid/ready pipeline.
// Stage p1 holds the captured input address; stage p2 holds the looked-up output.
module layer_neuron_pipe #(
  parameter  int FANIN  = 3,
  parameter  int IN_BW  = 2,
  parameter  int OUT_BW = 2,
  localparam int ADDR_W = FANIN * IN_BW,
  localparam int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] M0,
  input  logic              M0_valid,
  output logic              M0_ready,
  output logic [OUT_BW-1:0] M1,
  output logic              M1_valid,
  input  logic              M1_ready,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [OUT_BW-1:0] cfg_data,
  output logic [15:0]       res_count
);

  logic [OUT_BW-1:0] r_table [DEPTH];
  logic [ADDR_W-1:0] r_addr_p1;
  logic              r_vld_p1;
  logic [OUT_BW-1:0] r_data_p2;
  logic              r_vld_p2;
  logic [15:0]       r_res_cnt;

  logic w_adv_p2;
  logic w_xfer_in;
  logic w_xfer_out;

  assign w_adv_p2   = r_vld_p1 && (!r_vld_p2 || M1_ready);
  assign M0_ready   = !r_vld_p1 || (!r_vld_p2 || M1_ready);
  assign w_xfer_in  = M0_valid && M0_ready;
  assign w_xfer_out = r_vld_p2 && M1_ready;

  // Table writes never stall; a read in the same cycle sees the pre-write value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
    end else if (cfg_we) begin
      r_table[cfg_addr] <= cfg_data;
    end
  end

  // Stage p1: captured address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p1  <= 1'b0;
      r_addr_p1 <= '0;
    end else if (w_xfer_in) begin
      r_vld_p1  <= 1'b1;
      r_addr_p1 <= M0;
    end else if (w_adv_p2) begin
      r_vld_p1  <= 1'b0;
    end
  end

  // Stage p2: looked-up result, held while the consumer stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p2  <= 1'b0;
      r_data_p2 <= '0;
    end else if (w_adv_p2) begin
      r_vld_p2  <= 1'b1;
      r_data_p2 <= r_table[r_addr_p1];
    end else if (M1_ready) begin
      r_vld_p2  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res_cnt <= '0;
    end else if (w_xfer_out) begin
      r_res_cnt <= r_res_cnt + 16'd1;
    end
  end

  assign M1        = r_data_p2;
  assign M1_valid  = r_vld_p2;
  assign res_count = r_res_cnt;

endmodule

// File: tb/tb_layer_neuron_pipe.sv
// Directed bench for layer_neuron_pipe: reset, latency, streaming, backpressure,
// same-edge table write, mid-flight reset and result-counter wrap.
module tb_layer_neuron_pipe;

  logic       clk;
  logic       rst;
  logic [5:0] M0;
  logic       M0_valid;
  logic       M0_ready;
  logic [1:0] M1;
  logic       M1_valid;
  logic       M1_ready;
  logic       cfg_we;
  logic [5:0] cfg_addr;
  logic [1:0] cfg_data;
  logic [15:0] res_count;

  int checks = 0;
  int errors = 0;

  layer_neuron_pipe dut (
    .clk(clk), .rst(rst),
    .M0(M0), .M0_valid(M0_valid), .M0_ready(M0_ready),
    .M1(M1), .M1_valid(M1_valid), .M1_ready(M1_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .res_count(res_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [5:0] a, input logic [1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; M1_ready = 1'b1;
    M0 = 6'b111000; M0_valid = 1'b1;
    cfg_we = 1'b1; cfg_addr = 6'b111000; cfg_data = 2'b11;
    #2;
    checks++; if (M1_valid !== 1'b0) begin errors++; $display("FAIL rst_m1_valid: got %0b expected 0", M1_valid); end
    checks++; if (M1 !== 2'b00) begin errors++; $display("FAIL rst_m1: got %0h expected 0", M1); end
    checks++; if (res_count !== 16'h0) begin errors++; $display("FAIL rst_count: got %0h expected 0", res_count); end
    checks++; if (M0_ready !== 1'b1) begin errors++; $display("FAIL rst_m0_ready: got %0b expected 1", M0_ready); end
    tick(); tick(); tick();
    checks++; if (M1_valid !== 1'b0) begin errors++; $display("FAIL rst_no_xfer: got %0b expected 0", M1_valid); end
    cfg_we = 1'b0; M0_valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_latency();
    M0 = 6'b111000; M0_valid = 1'b1; M1_ready = 1'b1;
    #1;
    checks++; if (M0_ready !== 1'b1) begin errors++; $display("FAIL lat_ready: got %0b expected 1", M0_ready); end
    tick();
    M0_valid = 1'b0;
    checks++; if (M1_valid !== 1'b0) begin errors++; $display("FAIL lat_early: got %0b expected 0", M1_valid); end
    tick();
    checks++; if (M1_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: got %0b expected 1", M1_valid); end
    checks++; if (M1 !== 2'b00) begin errors++; $display("FAIL lat_data: got %0h expected 0", M1); end
    tick();
    checks++; if (M1_valid !== 1'b0) begin errors++; $display("FAIL lat_drain: got %0b expected 0", M1_valid); end
    checks++; if (res_count !== 16'd1) begin errors++; $display("FAIL lat_count: got %0d expected 1", res_count); end
  endtask

  task automatic test_back_to_back();
    cfg_write(6'b111000, 2'b10);
    cfg_write(6'b000010, 2'b10);
    M1_ready = 1'b1;
    M0 = 6'b111000; M0_valid = 1'b1;
    #1;
    checks++; if (M0_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0: got %0b expected 1", M0_ready); end
    tick();
    M0 = 6'b000010;
    #1;
    checks++; if (M0_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %0b expected 1", M0_ready); end
    tick();
    M0_valid = 1'b0;
    checks++; if (M1_valid !== 1'b1 || M1 !== 2'b10) begin errors++; $display("FAIL b2b_first: got v=%0b d=%0h expected v=1 d=2", M1_valid, M1); end
    tick();
    checks++; if (M1_valid !== 1'b1 || M1 !== 2'b10) begin errors++; $display("FAIL b2b_second: got v=%0b d=%0h expected v=1 d=2", M1_valid, M1); end
    tick();
    checks++; if (M1_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %0b expected 0", M1_valid); end
    checks++; if (res_count !== 16'd3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", res_count); end
  endtask

  task automatic test_backpressure();
    logic [5:0] addrs [4];
    logic [1:0] exp_d [4];
    int idx, k;
    addrs = '{6'd1, 6'd2, 6'd3, 6'd4};
    exp_d = '{2'd1, 2'd2, 2'd3, 2'd0};
    cfg_write(6'd1, 2'd1);
    cfg_write(6'd2, 2'd2);
    cfg_write(6'd3, 2'd3);
    cfg_write(6'd4, 2'd0);
    idx = 0; k = 0;
    M1_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      M0_valid = (idx < 4);
      M0 = addrs[idx < 4 ? idx : 0];
      #1;
      if (c >= 2) begin
        checks++; if (M0_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_c%0d: got %0b expected 0", c, M0_ready); end
        checks++; if (M1_valid !== 1'b1 || M1 !== exp_d[0]) begin errors++; $display("FAIL bp_stable_c%0d: got v=%0b d=%0h expected v=1 d=%0h", c, M1_valid, M1, exp_d[0]); end
      end
      if (M0_valid && M0_ready) idx++;
      tick();
    end
    checks++; if (idx !== 2) begin errors++; $display("FAIL bp_accepts: got %0d expected 2", idx); end
    M1_ready = 1'b1;
    for (int c = 0; c < 20 && k < 4; c++) begin
      M0_valid = (idx < 4);
      M0 = addrs[idx < 4 ? idx : 0];
      #1;
      if (M1_valid) begin
        checks++; if (M1 !== exp_d[k]) begin errors++; $display("FAIL bp_order%0d: got %0h expected %0h", k, M1, exp_d[k]); end
        k++;
      end
      if (M0_valid && M0_ready) idx++;
      tick();
    end
    M0_valid = 1'b0;
    checks++; if (k !== 4) begin errors++; $display("FAIL bp_results: got %0d expected 4", k); end
    tick();
    checks++; if (M1_valid !== 1'b0) begin errors++; $display("FAIL bp_dup: got %0b expected 0", M1_valid); end
    checks++; if (res_count !== 16'd7) begin errors++; $display("FAIL bp_count: got %0d expected 7", res_count); end
  endtask

  task automatic test_same_edge_write();
    cfg_write(6'b011110, 2'b00);
    M1_ready = 1'b1;
    M0 = 6'b011110; M0_valid = 1'b1;
    tick();
    M0_valid = 1'b0;
    cfg_we = 1'b1; cfg_addr = 6'b011110; cfg_data = 2'b01;
    tick();
    cfg_we = 1'b0;
    checks++; if (M1_valid !== 1'b1 || M1 !== 2'b00) begin errors++; $display("FAIL sew_old: got v=%0b d=%0h expected v=1 d=0", M1_valid, M1); end
    M0_valid = 1'b1;
    tick();
    M0_valid = 1'b0;
    tick();
    checks++; if (M1_valid !== 1'b1 || M1 !== 2'b01) begin errors++; $display("FAIL sew_new: got v=%0b d=%0h expected v=1 d=1", M1_valid, M1); end
    tick();
    checks++; if (res_count !== 16'd9) begin errors++; $display("FAIL sew_count: got %0d expected 9", res_count); end
  endtask

  task automatic test_reset_flight();
    M1_ready = 1'b0;
    M0 = 6'd1; M0_valid = 1'b1;
    tick();
    M0 = 6'd2;
    tick();
    M0_valid = 1'b0;
    checks++; if (M1_valid !== 1'b1) begin errors++; $display("FAIL rf_loaded: got %0b expected 1", M1_valid); end
    #1;
    rst = 1'b0;
    #1;
    checks++; if (M1_valid !== 1'b0) begin errors++; $display("FAIL rf_async_valid: got %0b expected 0", M1_valid); end
    checks++; if (M1 !== 2'b00) begin errors++; $display("FAIL rf_async_data: got %0h expected 0", M1); end
    checks++; if (res_count !== 16'd0) begin errors++; $display("FAIL rf_async_count: got %0d expected 0", res_count); end
    M1_ready = 1'b1;
    tick();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (M1_valid !== 1'b0) begin errors++; $display("FAIL rf_stale_c%0d: got %0b expected 0", c, M1_valid); end
    end
    checks++; if (res_count !== 16'd0) begin errors++; $display("FAIL rf_count: got %0d expected 0", res_count); end
  endtask

  task automatic test_wrap();
    int acc;
    acc = 0;
    M1_ready = 1'b1;
    M0 = 6'd1; M0_valid = 1'b1;
    #1;
    for (int c = 0; c < 65536; c++) begin
      if (M0_ready) acc++;
      tick();
      if (c == 1) begin
        checks++; if (M1_valid !== 1'b1 || M1 !== 2'b00) begin errors++; $display("FAIL wrap_cleared_table: got v=%0b d=%0h expected v=1 d=0", M1_valid, M1); end
      end
    end
    M0_valid = 1'b0;
    checks++; if (acc !== 65536) begin errors++; $display("FAIL wrap_accepts: got %0d expected 65536", acc); end
    tick();
    checks++; if (res_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got %0h expected ffff", res_count); end
    tick();
    checks++; if (res_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %0h expected 0", res_count); end
    tick();
    checks++; if (M1_valid !== 1'b0 || res_count !== 16'h0000) begin errors++; $display("FAIL wrap_idle: got v=%0b cnt=%0h expected v=0 cnt=0", M1_valid, res_count); end
  endtask

  initial begin
    M0 = '0; M0_valid = 1'b0; M1_ready = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    rst = 1'b0;
    test_reset();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_same_edge_write();
    test_reset_flight();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
